req_encoder_seq: RTL and testbench
==================================

Name: req_encoder_seq

Overview:
- Sequential multi-hot to binary encoder: the encoding counterpart of the team's 2-to-4 decoder.
- Captures a request vector and emits the index of every set bit, lowest index first, one code per valid/ready transfer.
- Sits between request-generating logic and any consumer that drives a decoder's sel_in/en_in pair.

Parameters:
N, 4, number of request lines (power of two, >= 2)
CODE_W, 2, code width; must equal log2(N)

Ports:
clk_in  input  1  clock, rising-edge
rst_n_in  input  1  asynchronous active-low reset
en_in  input  1  block enable; low freezes progress
load_in  input  1  capture strobe for req_in
req_in  input  N  multi-hot request vector
ready_in  input  1  consumer accepts code_out
code_out  output  CODE_W  index of lowest pending request
valid_out  output  1  code_out is valid
busy_out  output  1  batch in progress (state != IDLE)
pending_out  output  N  requests not yet transferred
done_out  output  1  one-cycle pulse: batch finished
err_out  output  1  one-cycle pulse: load_in rejected while busy

Behaviour:
- Reset (rst_n_in low, asynchronous): state=IDLE, pending=0, done_out=0, err_out=0. Hence code_out=0, valid_out=0, busy_out=0, pending_out=0.
- Reset mid-batch: the batch is discarded and no done_out is produced.
- FSM states: IDLE, EMIT.
- IDLE, en_in=1, load_in=1 at edge k:
  - pending<=req_in.
  - req_in!=0: state<=EMIT; valid_out high in cycle k+1 (1-cycle latency).
  - req_in==0: stay IDLE; done_out=1 in cycle k+1; valid_out never asserts.
- IDLE, en_in=0: load_in ignored, no err_out.
- EMIT:
  - code_out = index of lowest set bit of pending, decoded from registers only.
  - valid_out = en_in (combinational gate).
  - Transfer occurs at an edge where en_in=1 and ready_in=1. The transferred bit clears in pending.
  - If remaining pending!=0: stay EMIT; the next code is presented the following cycle with no bubble. Max throughput is one code per cycle.
  - If remaining pending==0: state<=IDLE; done_out=1 for exactly the next cycle.
- valid_out stability: once high, code_out holds until the transfer or until en_in drops. If en_in drops, pending is preserved and emission resumes with the same code when en_in returns.
- load_in while EMIT: ignored; pending unchanged; err_out=1 in the next cycle if en_in=1.
- load_in on the same edge as the final transfer: rejected (err_out), because state is still EMIT at that edge.
- ready_in while valid_out=0: no effect.
- Index arithmetic:
  - Lowest-index priority, N-1 highest index.
  - code_out is zero-extended to CODE_W.
  - No wrap-around; each batch scans upward from index 0.
- busy_out = (state==EMIT). pending_out = the pending register.

Test Plan:
- Reset mid-batch: assert rst_n_in asynchronously with pending=4'b0110 -> outputs zero immediately, no done_out; after release, load 4'b0001 -> code 0 transferred normally.
- Basic batch: load req_in=4'b1011, ready_in=1 -> codes 0,1,3 in three consecutive cycles starting one cycle after load; pending_out 1011->1010->1000->0000; done_out pulses once in the cycle after code 3.
- Backpressure: load 4'b0100, ready_in=0 for 5 cycles -> valid_out=1, code_out=2 held for all 5 cycles; ready_in=1 -> single transfer, done_out next cycle.
- Zero load: load req_in=4'b0000 -> valid_out stays 0, busy_out stays 0, done_out=1 in the next cycle.
- Overrun: during a 4'b1111 batch, pulse load_in=1 with req_in=4'b0001 -> err_out=1 next cycle, pending unaffected, remaining codes still 1,2,3 in order.
- Enable freeze: batch 4'b1100 with en_in dropped after code 2 is presented -> valid_out=0, pending_out=4'b1100 held; en_in=1 -> code 2 then code 3, then done_out.

Source files
------------

// File: rtl/req_encoder_seq.sv
// req_encoder_seq: sequential multi-hot to binary encoder that emits each set request index, lowest first, one per valid/ready transfer
// Ports:
//   clk_in       rising-edge clock
//   rst_n_in     asynchronous active-low reset
//   en_in        block enable; low freezes progress and gates valid_out
//   load_in      capture strobe for req_in (honoured only in IDLE)
//   req_in       multi-hot request vector
//   ready_in     consumer accepts code_out
//   code_out     index of the lowest pending request
//   valid_out    code_out is valid
//   busy_out     batch in progress
//   pending_out  requests not yet transferred
//   done_out     one-cycle pulse when a batch finishes
//   err_out      one-cycle pulse when a load is rejected while busy
module req_encoder_seq #(
    parameter int N      = 4,
    parameter int CODE_W = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              en_in,
    input  logic              load_in,
    input  logic [N-1:0]      req_in,
    input  logic              ready_in,
    output logic [CODE_W-1:0] code_out,
    output logic              valid_out,
    output logic              busy_out,
    output logic [N-1:0]      pending_out,
    output logic              done_out,
    output logic              err_out
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [N-1:0] remain;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    // x & (x-1) drops the lowest set bit, i.e. the code being transferred
    assign remain = pending_q & (pending_q - N'(1));
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (en_in) begin
            if (state_q == IDLE) begin
                if (load_in) begin
                    pending_d = req_in;
                    state_d   = (req_in != '0) ? EMIT : IDLE;
                    done_d    = (req_in == '0);
                end
            end else begin
                err_d = load_in;
                if (ready_in) begin
                    pending_d = remain;
                    state_d   = (remain != '0) ? EMIT : IDLE;
                    done_d    = (remain == '0);
                end
            end
        end
    end
    always_comb begin
        code_out = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending_q[i]) code_out = CODE_W'(i);
        valid_out   = (state_q == EMIT) && en_in;
        busy_out    = (state_q == EMIT);
        pending_out = pending_q;
        done_out    = done_q;
        err_out     = err_q;
    end
endmodule

// File: tb/tb_req_encoder_seq.sv
// tb_req_encoder_seq: scoreboard bench for req_encoder_seq with directed batches
// Ports: none (self-contained testbench)
module tb_req_encoder_seq;
    localparam int EV_DONE = 0;
    localparam int EV_ERR  = 1;
    logic       clk_in, rst_n_in, en_in, load_in, ready_in;
    logic [3:0] req_in;
    logic [1:0] code_out;
    logic       valid_out, busy_out, done_out, err_out;
    logic [3:0] pending_out;
    int checks = 0;
    int errors = 0;
    int exp_code[$];
    int exp_evt[$];
    req_encoder_seq #(.N(4), .CODE_W(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .load_in(load_in),
        .req_in(req_in), .ready_in(ready_in), .code_out(code_out),
        .valid_out(valid_out), .busy_out(busy_out), .pending_out(pending_out),
        .done_out(done_out), .err_out(err_out)
    );
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    task automatic load_batch(input logic [3:0] r);
        load_in = 1'b1;
        req_in  = r;
        tick();
        load_in = 1'b0;
    endtask
    // Monitor: pops the scoreboard whenever the DUT presents an event or a transfer
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (err_out) begin
                if (exp_evt.size() == 0) check("unexpected_err", 1, 0);
                else check("evt_err", exp_evt.pop_front(), EV_ERR);
            end
            if (done_out) begin
                if (exp_evt.size() == 0) check("unexpected_done", 1, 0);
                else check("evt_done", exp_evt.pop_front(), EV_DONE);
            end
            if (valid_out && ready_in) begin
                if (exp_code.size() == 0) check("unexpected_code", int'(code_out), -1);
                else check("code", int'(code_out), exp_code.pop_front());
            end
        end
    end
    initial begin
        rst_n_in = 1'b1; en_in = 1'b0; load_in = 1'b0; req_in = '0; ready_in = 1'b0;
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_pending", pending_out, 0);
        check("rst_done", done_out, 0);
        check("rst_err", err_out, 0);
        check("rst_code", code_out, 0);
        tick();
        rst_n_in = 1'b1;
        en_in = 1'b1;
        tick();
        // reset mid-batch
        load_batch(4'b0110);
        check("mid_pending", pending_out, 4'b0110);
        check("mid_valid", valid_out, 1);
        check("mid_code", code_out, 1);
        #2 rst_n_in = 1'b0;
        #1;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_pending", pending_out, 0);
        check("mid_rst_busy", busy_out, 0);
        tick();
        rst_n_in = 1'b1;
        tick();
        check("mid_no_done", done_out, 0);
        ready_in = 1'b1;
        exp_code.push_back(0);
        exp_evt.push_back(EV_DONE);
        load_batch(4'b0001);
        check("post_rst_code", code_out, 0);
        repeat (3) tick();
        // basic batch
        exp_code.push_back(0); exp_code.push_back(1); exp_code.push_back(3);
        exp_evt.push_back(EV_DONE);
        load_batch(4'b1011);
        check("basic_p0", pending_out, 4'b1011);
        tick();
        check("basic_p1", pending_out, 4'b1010);
        tick();
        check("basic_p2", pending_out, 4'b1000);
        tick();
        check("basic_p3", pending_out, 4'b0000);
        check("basic_done", done_out, 1);
        tick();
        check("basic_done_end", done_out, 0);
        // backpressure
        ready_in = 1'b0;
        exp_code.push_back(2);
        exp_evt.push_back(EV_DONE);
        load_batch(4'b0100);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", valid_out, 1);
            check("bp_code", code_out, 2);
            if (i < 4) tick();
        end
        ready_in = 1'b1;
        tick();
        check("bp_done", done_out, 1);
        check("bp_busy", busy_out, 0);
        tick();
        // zero load
        exp_evt.push_back(EV_DONE);
        load_batch(4'b0000);
        check("zero_valid", valid_out, 0);
        check("zero_busy", busy_out, 0);
        check("zero_done", done_out, 1);
        tick();
        check("zero_valid2", valid_out, 0);
        // overrun
        exp_code.push_back(0); exp_code.push_back(1); exp_code.push_back(2); exp_code.push_back(3);
        exp_evt.push_back(EV_ERR);
        exp_evt.push_back(EV_DONE);
        load_batch(4'b1111);
        load_batch(4'b0001);
        check("ovr_err", err_out, 1);
        check("ovr_pending", pending_out, 4'b1110);
        check("ovr_code", code_out, 1);
        tick();
        check("ovr_err_end", err_out, 0);
        repeat (4) tick();
        // enable freeze
        exp_code.push_back(2); exp_code.push_back(3);
        exp_evt.push_back(EV_DONE);
        load_batch(4'b1100);
        check("frz_code_first", code_out, 2);
        en_in = 1'b0;
        #1;
        check("frz_valid_drop", valid_out, 0);
        tick();
        tick();
        check("frz_valid", valid_out, 0);
        check("frz_pending", pending_out, 4'b1100);
        check("frz_busy", busy_out, 1);
        en_in = 1'b1;
        #1;
        check("frz_resume_valid", valid_out, 1);
        check("frz_resume_code", code_out, 2);
        tick();
        check("frz_code_next", code_out, 3);
        tick();
        check("frz_done", done_out, 1);
        repeat (3) tick();
        check("left_codes", exp_code.size(), 0);
        check("left_events", exp_evt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
